// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_arb_pkg;

   localparam int DEF_AW              = 32;
   localparam int DEF_DW              = 32;
   localparam int DEF_MAX_DATA_STREAK = 3;

   // Port state: idle, or driving the memory port for one requester.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      BUSY_IF = 2'b01,
      BUSY_DM = 2'b10
   } arb_state_t;

   // Counter width able to hold 0..max_streak, never narrower than one bit.
   function automatic int streak_width(input int max_streak);
      int w;
      w = $clog2(max_streak + 1);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Counts data grants that overtake a waiting fetch, so the fetch side cannot starve.
module arb_streak_counter
   import mem_arb_pkg::*;
#(
   parameter int SW = 2
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic          dm_gnt,
   input  logic          if_gnt,
   input  logic [SW-1:0] limit,
   output logic          streak_max
);

   logic [SW-1:0] streak_r;

   // Restart when the fetch is served or not waiting; otherwise count data wins up to the limit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         streak_r <= {SW{1'b0}};
      end else if (if_gnt || !if_req) begin
         streak_r <= {SW{1'b0}};
      end else if (dm_gnt && (streak_r < limit)) begin
         streak_r <= streak_r + SW'(1);
      end else begin
         streak_r <= streak_r;
      end
   end

   // A limit of zero is always reached, giving the fetch side strict priority.
   assign streak_max = (streak_r >= limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared single-cycle memory port between instruction fetch and data access.
// A grant in cycle N drives the port in N+1 and returns data with a valid pulse in N+2.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK,
   parameter int AW              = DEF_AW,
   parameter int DW              = DEF_DW
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic [DW-1:0] if_rdata,
   output logic          if_valid,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_valid,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          stall_if,
   output logic          stall_mem
);

   localparam int            SW           = streak_width(MAX_DATA_STREAK);
   localparam logic [SW-1:0] STREAK_LIMIT = SW'(MAX_DATA_STREAK);

   arb_state_t    state_r;
   logic          mem_en_r;
   logic          mem_we_r;
   logic [AW-1:0] mem_addr_r;
   logic [DW-1:0] mem_wdata_r;
   logic [DW-1:0] if_rdata_r;
   logic [DW-1:0] dm_rdata_r;
   logic          if_valid_r;
   logic          dm_valid_r;

   logic          if_gnt_s;
   logic          dm_gnt_s;
   logic          streak_max_s;

   arb_streak_counter #(
      .SW (SW)
   ) u_streak (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_req     (if_req),
      .dm_gnt     (dm_gnt_s),
      .if_gnt     (if_gnt_s),
      .limit      (STREAK_LIMIT),
      .streak_max (streak_max_s)
   );

   // Grant selection: data wins unless the fetch has already waited through a full streak.
   always_comb begin
      if_gnt_s = 1'b0;
      dm_gnt_s = 1'b0;
      if (!rst_n) begin
         if_gnt_s = 1'b0;
         dm_gnt_s = 1'b0;
      end else if (if_req && (!dm_req || streak_max_s)) begin
         if_gnt_s = 1'b1;
      end else if (dm_req) begin
         dm_gnt_s = 1'b1;
      end else begin
         if_gnt_s = 1'b0;
         dm_gnt_s = 1'b0;
      end
   end

   // Port FSM: launch the granted access next cycle and capture its read data the cycle after.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {AW{1'b0}};
         mem_wdata_r <= {DW{1'b0}};
         if_rdata_r  <= {DW{1'b0}};
         dm_rdata_r  <= {DW{1'b0}};
         if_valid_r  <= 1'b0;
         dm_valid_r  <= 1'b0;
      end else begin
         // Launch stage: the winner's request is latched onto the port registers.
         if (if_gnt_s) begin
            state_r     <= BUSY_IF;
            mem_en_r    <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= if_addr;
            mem_wdata_r <= {DW{1'b0}};
         end else if (dm_gnt_s) begin
            state_r     <= BUSY_DM;
            mem_en_r    <= 1'b1;
            mem_we_r    <= dm_we;
            mem_addr_r  <= dm_addr;
            mem_wdata_r <= dm_wdata;
         end else begin
            state_r     <= IDLE;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
         end

         // Response stage: the access on the port this cycle completes at this edge.
         case (state_r)
            BUSY_IF: begin
               if_valid_r <= 1'b1;
               if_rdata_r <= mem_rdata;
               dm_valid_r <= 1'b0;
               dm_rdata_r <= dm_rdata_r;
            end
            BUSY_DM: begin
               if_valid_r <= 1'b0;
               if_rdata_r <= if_rdata_r;
               dm_valid_r <= 1'b1;
               dm_rdata_r <= mem_we_r ? {DW{1'b0}} : mem_rdata;
            end
            IDLE: begin
               if_valid_r <= 1'b0;
               if_rdata_r <= if_rdata_r;
               dm_valid_r <= 1'b0;
               dm_rdata_r <= dm_rdata_r;
            end
            default: begin
               if_valid_r <= 1'b0;
               if_rdata_r <= if_rdata_r;
               dm_valid_r <= 1'b0;
               dm_rdata_r <= dm_rdata_r;
            end
         endcase
      end
   end

   assign if_gnt    = if_gnt_s;
   assign dm_gnt    = dm_gnt_s;
   assign stall_if  = if_req & ~if_gnt_s;
   assign stall_mem = dm_req & ~dm_gnt_s;

   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign if_rdata  = if_rdata_r;
   assign if_valid  = if_valid_r;
   assign dm_rdata  = dm_rdata_r;
   assign dm_valid  = dm_valid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-by-cycle vector table plus hand-written
// sequences for back-to-back fetches, the starvation guard and reset mid-transaction.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] mem_rdata;

   logic        if_gnt, if_valid, dm_gnt, dm_valid, mem_en, mem_we, stall_if, stall_mem;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

   logic        if_gnt0, if_valid0, dm_gnt0, dm_valid0, mem_en0, mem_we0, stall_if0, stall_mem0;
   logic [31:0] if_rdata0, dm_rdata0, mem_addr0, mem_wdata0;

   int errors;
   int checks;

   mem_port_arbiter #(.MAX_DATA_STREAK(3), .AW(32), .DW(32)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
   );

   // Second instance with strict fetch priority, fed the same stimulus.
   mem_port_arbiter #(.MAX_DATA_STREAK(0), .AW(32), .DW(32)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt0), .if_rdata(if_rdata0), .if_valid(if_valid0),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt0), .dm_rdata(dm_rdata0), .dm_valid(dm_valid0),
      .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .mem_rdata(mem_rdata), .stall_if(stall_if0), .stall_mem(stall_mem0)
   );

   typedef struct packed {
      logic        rst_n;
      logic        if_req;
      logic [31:0] if_addr;
      logic        dm_req;
      logic        dm_we;
      logic [31:0] dm_addr;
      logic [31:0] dm_wdata;
      logic [31:0] mem_rdata;
   } in_t;

   typedef struct packed {
      logic        if_gnt;
      logic        dm_gnt;
      logic        stall_if;
      logic        stall_mem;
      logic        mem_en;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        if_valid;
      logic [31:0] if_rdata;
      logic        dm_valid;
      logic [31:0] dm_rdata;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   vec_t vecs [13];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input in_t v);
      rst_n     = v.rst_n;
      if_req    = v.if_req;
      if_addr   = v.if_addr;
      dm_req    = v.dm_req;
      dm_we     = v.dm_we;
      dm_addr   = v.dm_addr;
      dm_wdata  = v.dm_wdata;
      mem_rdata = v.mem_rdata;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      drive('{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0});
   endtask

   initial begin
      out_t act;
      errors = 0;
      checks = 0;

      //           rst if  if_addr      dm we dm_addr      dm_wdata       mem_rdata          ig dg si sm en we mem_addr     mem_wdata      iv if_rdata       dv dm_rdata
      vecs[0]  = '{'{1'b0,1'b1,32'h4, 1'b1,1'b0,32'h8, 32'h0, 32'h0},         '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0, 32'h0, 1'b0,32'h0, 1'b0,32'h0}};
      vecs[1]  = '{'{1'b1,1'b1,32'h4, 1'b0,1'b0,32'h0, 32'h0, 32'h8C010000},  '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0, 1'b0,32'h0, 1'b0,32'h0}};
      vecs[2]  = '{'{1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0, 32'h0, 32'h8C010000},  '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h4, 32'h0, 1'b0,32'h0, 1'b0,32'h0}};
      vecs[3]  = '{'{1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0, 32'h0, 32'h11111111},  '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h4, 32'h0, 1'b1,32'h8C010000, 1'b0,32'h0}};
      vecs[4]  = '{'{1'b1,1'b1,32'h20,1'b1,1'b1,32'h10,32'hDEADBEEF,32'h0},   '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h4, 32'h0, 1'b0,32'h8C010000, 1'b0,32'h0}};
      vecs[5]  = '{'{1'b1,1'b1,32'h20,1'b0,1'b0,32'h0, 32'h0, 32'h22222222},  '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,32'h10,32'hDEADBEEF,1'b0,32'h8C010000, 1'b0,32'h0}};
      vecs[6]  = '{'{1'b1,1'b1,32'h24,1'b0,1'b0,32'h0, 32'h0, 32'h33333333},  '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,32'h20,32'h0, 1'b0,32'h8C010000, 1'b1,32'h0}};
      vecs[7]  = '{'{1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0, 32'h0, 32'h44444444},  '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h24,32'h0, 1'b1,32'h33333333, 1'b0,32'h0}};
      vecs[8]  = '{'{1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0, 32'h0, 32'h55555555},  '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h24,32'h0, 1'b1,32'h44444444, 1'b0,32'h0}};
      vecs[9]  = '{'{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h30,32'h0, 32'h0},         '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h24,32'h0, 1'b0,32'h44444444, 1'b0,32'h0}};
      vecs[10] = '{'{1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0, 32'h0, 32'hCAFEF00D},  '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h30,32'h0, 1'b0,32'h44444444, 1'b0,32'h0}};
      vecs[11] = '{'{1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0, 32'h0, 32'h0},         '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h30,32'h0, 1'b0,32'h44444444, 1'b1,32'hCAFEF00D}};
      vecs[12] = '{'{1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0, 32'h0, 32'h0},         '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h30,32'h0, 1'b0,32'h44444444, 1'b0,32'hCAFEF00D}};

      // Initial reset edge to bring all registers to a known state.
      drive('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0});
      next_cycle();

      // Table: each row is one cycle; outputs sampled mid-cycle before the edge.
      for (int v = 0; v < 13; v++) begin
         drive(vecs[v].i);
         @(negedge clk);
         act = {if_gnt, dm_gnt, stall_if, stall_mem, mem_en, mem_we, mem_addr, mem_wdata,
                if_valid, if_rdata, dm_valid, dm_rdata};
         chk($sformatf("vec%0d", v), 160'(act), 160'(vecs[v].o));
         next_cycle();
      end

      // Back-to-back fetches at addresses 0..3, memory returns 0xA0000000 + address.
      for (int k = 0; k < 7; k++) begin
         rst_n    = 1'b1;
         if_req   = (k < 4);
         if_addr  = 32'(k);
         dm_req   = 1'b0;
         dm_we    = 1'b0;
         dm_addr  = 32'h0;
         dm_wdata = 32'h0;
         mem_rdata = (k >= 1 && k <= 4) ? (32'hA0000000 + 32'(k - 1)) : 32'h0;
         @(negedge clk);
         chk($sformatf("b2b_if_gnt%0d", k), 160'(if_gnt), 160'(k < 4));
         chk($sformatf("b2b_mem_en%0d", k), 160'(mem_en), 160'(k >= 1 && k <= 4));
         if (k >= 1 && k <= 4) begin
            chk($sformatf("b2b_mem_addr%0d", k), 160'(mem_addr), 160'(32'(k - 1)));
         end else begin
            chk($sformatf("b2b_mem_we%0d", k), 160'(mem_we), 160'(1'b0));
         end
         chk($sformatf("b2b_if_valid%0d", k), 160'(if_valid), 160'(k >= 2 && k <= 5));
         if (k >= 2 && k <= 5) begin
            chk($sformatf("b2b_if_rdata%0d", k), 160'(if_rdata), 160'(32'hA0000000 + 32'(k - 2)));
         end else begin
            chk($sformatf("b2b_dm_valid%0d", k), 160'(dm_valid), 160'(1'b0));
         end
         next_cycle();
      end

      // Starvation guard: both requesters held high; expect D,D,D,I,D,D (strict instance: all I).
      for (int k = 0; k < 6; k++) begin
         rst_n     = 1'b1;
         if_req    = 1'b1;
         if_addr   = 32'h100;
         dm_req    = 1'b1;
         dm_we     = 1'b0;
         dm_addr   = 32'h200;
         dm_wdata  = 32'h0;
         mem_rdata = 32'h0;
         @(negedge clk);
         chk($sformatf("starve_if_gnt%0d", k), 160'(if_gnt), 160'(k == 3));
         chk($sformatf("starve_dm_gnt%0d", k), 160'(dm_gnt), 160'(k != 3));
         chk($sformatf("starve_stall_if%0d", k), 160'(stall_if), 160'(k != 3));
         chk($sformatf("strict_if_gnt%0d", k), 160'({if_gnt0, dm_gnt0, stall_mem0}), 160'(3'b101));
         next_cycle();
      end

      // Drain outstanding responses.
      for (int k = 0; k < 3; k++) begin
         idle_inputs();
         next_cycle();
      end

      // Reset mid-transaction: data read granted, then reset in the launch cycle.
      drive('{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0});
      @(negedge clk);
      chk("rst_dm_gnt", 160'(dm_gnt), 160'(1'b1));
      next_cycle();

      drive('{1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 32'h77777777});
      @(negedge clk);
      chk("rst_gnt_suppressed", 160'({if_gnt, dm_gnt}), 160'(2'b00));
      chk("rst_inflight_port", 160'({mem_en, mem_addr}), 160'({1'b1, 32'h40}));
      next_cycle();

      idle_inputs();
      @(negedge clk);
      act = {if_gnt, dm_gnt, stall_if, stall_mem, mem_en, mem_we, mem_addr, mem_wdata,
             if_valid, if_rdata, dm_valid, dm_rdata};
      chk("rst_all_zero", 160'(act), 160'(0));
      next_cycle();

      @(negedge clk);
      chk("rst_no_late_valid", 160'({dm_valid, if_valid, mem_en}), 160'(3'b000));
      next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_DATA_STREAK, default 3, is the maximum number of consecutive data grants while a fetch request waits.
REQ-002 Parameter AW, default 32, is the address width; DW, default 32, is the data width.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  is a synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 if_req  input  1  is the instruction-fetch read request.
REQ-006 if_addr  input  AW  is the fetch address.
REQ-007 if_gnt  output  1  is the fetch grant pulse.
REQ-008 if_rdata  output  DW  is the fetched instruction.
REQ-009 if_valid  output  1  means if_rdata is valid for one cycle.
REQ-010 dm_req  input  1  is the data-access request.
REQ-011 dm_we  input  1  selects data write (1) or data read (0).
REQ-012 dm_addr  input  AW  is the data address.
REQ-013 dm_wdata  input  DW  is the write data.
REQ-014 dm_gnt  output  1  is the data grant pulse.
REQ-015 dm_rdata  output  DW  is the read data.
REQ-016 dm_valid  output  1  is the data completion pulse.
REQ-017 mem_en  output  1  is the shared memory port enable.
REQ-018 mem_we  output  1  is the memory write enable.
REQ-019 mem_addr  output  AW  is the memory address.
REQ-020 mem_wdata  output  DW  is the memory write data.
REQ-021 mem_rdata  input  DW  is the asynchronous memory read data, valid in the same cycle as mem_en.
REQ-022 stall_if  output  1  holds the PC and IF/ID buffer.
REQ-023 stall_mem  output  1  holds the EX/MEM and MEM/WB buffers.

Function
REQ-024 FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE: no access in flight.
- BUSY_x: memory port driven for requester x this cycle.
REQ-025 Arbitration is evaluated combinationally in IDLE and in every BUSY_x cycle, so grants can issue back-to-back at one transaction per cycle.
REQ-026 Arbitration priority:
- dm_req wins over if_req.
- Exception: if_req wins when streak == MAX_DATA_STREAK and if_req=1.
REQ-027 if_gnt and dm_gnt are combinational, mutually exclusive, and never asserted without the matching req.
REQ-028 On a grant in cycle N:
- addr, we and wdata are registered at the edge ending N.
- State goes to BUSY_winner.
- mem_en=1 with mem_we/mem_addr/mem_wdata come from registers in cycle N+1.
REQ-029 mem_rdata is registered at the edge ending N+1; the matching *_valid pulses for exactly one cycle in N+2 with *_rdata.
REQ-030 Data writes also pulse dm_valid in N+2, with dm_rdata = 0.
REQ-031 Fetch transactions always drive mem_we=0.
REQ-032 With no grant in a cycle, next state = IDLE; mem_en=0 and mem_we=0 in IDLE.
REQ-033 Requesters hold req/addr/wdata stable until gnt; req still high in the cycle after gnt is a new request.
REQ-034 stall_if = if_req & ~if_gnt; stall_mem = dm_req & ~dm_gnt (combinational).
REQ-035 Streak counter, width clog2(MAX_DATA_STREAK+1):
- Increments on dm_gnt while if_req=1, saturating at MAX_DATA_STREAK.
- Clears on if_gnt or whenever if_req=0.
REQ-036 Simultaneous if_req and dm_req with streak < MAX_DATA_STREAK grants dm only; the fetch waits with stall_if=1.
REQ-037 MAX_DATA_STREAK = 0 gives strict fetch priority.
REQ-038 *_rdata holds its last value between valid pulses.

Reset
REQ-039 While rst_n=0 at a clock edge:
- State becomes IDLE and streak becomes 0.
- All registered outputs (mem_*, *_rdata, *_valid) become 0.
REQ-040 Reset mid-transaction discards the in-flight access: no *_valid pulse, and mem_en=0 in the cycle after reset.
REQ-041 Grants are suppressed (held 0) during any cycle with rst_n=0.

Structure
REQ-042 Package mem_arb_pkg holds:
- the state enumeration;
- AW/DW defaults;
- the MAX_DATA_STREAK default.
REQ-043 The streak counter is one sub-module, arb_streak_counter, with inputs if_req, dm_gnt, if_gnt and limit, and output streak_max.
REQ-044 No other sub-modules are used; the FSM, grant logic and response registers live in mem_port_arbiter.

Verification
REQ-045 Fetch only: if_req=1, if_addr=0x4 at cycle 0, mem_rdata=0x8C010000 → if_gnt cycle 0, mem_en/mem_addr=0x4 cycle 1, if_valid with if_rdata=0x8C010000 cycle 2.
REQ-046 Conflict: if_req=dm_req=1, dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF → dm_gnt, stall_if=1; mem_we=1 next cycle; dm_valid with dm_rdata=0 in cycle 2.
REQ-047 Starvation guard: dm_req and if_req held high for 6 cycles, MAX_DATA_STREAK=3 → grants DM, DM, DM, IF, DM, DM.
REQ-048 Back-to-back: if_req high for 4 cycles with addresses 0, 1, 2, 3 → mem_en high for 4 consecutive cycles, and 4 if_valid pulses in order.
REQ-049 Reset mid-op: dm read granted in cycle 0, rst_n=0 in cycle 1 → no dm_valid in cycle 2, all outputs 0, state IDLE.
